maxpool_thre_ctrl: RTL
======================

# maxpool_thre_ctrl

Sequencer for one binarised Block's max-pool/threshold stage. It loads N_CH per-channel thresholds from the shared threshold ROM into the channel comparators using a one-hot load strobe. It then counts incoming conv samples and asserts a window-fire pulse for each complete KERNEL-wide window at stride STRIDE, followed by a delayed output-valid. The block sits between the conv engine's sample-valid and the per-channel compare units, and replaces the free-running counters inside each max-pool stage with one explicit frame-level controller.

## Interface
- N_CH, 16, number of channels / thresholds to load
- ADDR_W, 4, threshold ROM address width (2^ADDR_W >= N_CH)
- KERNEL, 7, max-pool window length in samples
- STRIDE, 2, max-pool step in samples
- LEN_W, 10, width of frame-length and count fields
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame start request; honoured only in IDLE
- in_len  in  LEN_W  number of input samples in the frame; sampled when start is accepted
- in_val  in  1  one input sample (all channels) present this cycle
- in_rdy  out  1  high in RUN; upstream may assert in_val
- rom_en  out  1  threshold ROM read enable
- rom_addr  out  ADDR_W  threshold ROM address
- load_strobe  out  N_CH  one-hot; bit i loads ROM data into channel i comparator
- win_fire  out  1  the sample this cycle completes a pooling window
- out_val  out  1  comparator binary outputs are valid (win_fire delayed 1 cycle)
- out_cnt  out  LEN_W  number of windows emitted this frame
- busy  out  1  state != IDLE
- done  out  1  one-cycle end-of-frame pulse
- err  out  1  sticky: in_val seen outside RUN; cleared on accepted start

## Operation
- FSM states are IDLE, LOAD, RUN, DRAIN, DONE.
- **IDLE:** start=1 latches in_len, clears out_cnt and err, then moves to LOAD.
- **LOAD:**
  - Runs N_CH+1 cycles. In cycles 0..N_CH-1, rom_en=1 and rom_addr=cycle index.
  - The ROM has 1-cycle read latency, so load_strobe[i] is asserted in the cycle after addr i (cycles 1..N_CH). Exactly one bit is high in each of those cycles.
  - After the cycle with load_strobe[N_CH-1] high, the FSM moves to RUN.
- **RUN:**
  - in_rdy=1. Each in_val increments sample index k, starting from 0.
  - win_fire=1 on the cycle of the in_val for sample k when k >= KERNEL-1 and (k-(KERNEL-1)) mod STRIDE == 0.
  - When the in_val for sample in_len-1 is accepted, the FSM moves to DRAIN.
- **DRAIN:** one cycle, which allows the final out_val to emit; then move to DONE.
- **DONE:** done=1 for one cycle; then move to IDLE.
- out_val is win_fire registered once. out_cnt increments with each out_val.
- Expected windows per frame: (in_len-KERNEL)/STRIDE+1 (integer division) if in_len >= KERNEL, else 0.
- Boundary conditions:
  - in_len=0: RUN exits immediately to DRAIN; zero windows.
  - in_len < KERNEL: samples are consumed, no win_fire.
  - start while busy is ignored; the frame in progress is unaffected.
  - in_val in IDLE/LOAD/DRAIN/DONE: sample dropped, err set.
  - rst at any cycle: next cycle state IDLE, all outputs 0, counters 0; any partial threshold load is discarded.
  - out_cnt saturates at 2^LEN_W-1.

## Timing
- Reset values: every output is 0.
- Start accepted at cycle t:
  - rom_en=1 at t+1..t+N_CH.
  - load_strobe[i] at t+2+i.
  - in_rdy=1 from t+N_CH+2.
- win_fire is combinational from in_val and the registered sample count, with zero latency. out_val follows 1 cycle later.
- If the last sample is accepted at cycle s: DRAIN is s+1 (last out_val, if any), done is s+2, and busy falls at s+3. start can be accepted at s+3.
- Minimum frame overhead: N_CH+4 cycles plus in_len accepted samples.

## Structure
- A shared package (blk_ctrl_pkg) holds the state enum (IDLE, LOAD, RUN, DRAIN, DONE) and the default KERNEL/STRIDE constants used by all Block stages.
- The threshold loader is a natural sub-module, thre_loader: address counter, 1-cycle strobe alignment, one-hot shift. It is reused by the other Blocks.
- The window/stride counter and FSM stay in the top module.

## Test plan
- **Reset and load:** rst then start with N_CH=16 → rom_addr 0..15 on 16 consecutive cycles; load_strobe = 1<<i exactly one cycle after addr i; in_rdy rises at t+18.
- **Nominal frame:** in_len=20, KERNEL=7, STRIDE=2, in_val every cycle → win_fire at k=6,8,…,18; out_val 7 times; out_cnt=7; done 2 cycles after sample 19.
- **Gapped input and short frame:** in_val with random gaps, in_len=20 → same 7 windows, keyed to sample index; then in_len=5 → 0 windows, done still pulses.
- **Protocol errors:** start during LOAD and during RUN → ignored, frame completes normally; in_val during LOAD → err=1, sample not counted; next accepted start → err=0.
- **Reset mid-frame:** rst asserted at sample 10 of in_len=20 → next cycle all outputs 0, state IDLE; new start performs a full 16-entry reload.
- **Edge lengths:** in_len=7 → exactly 1 window, at k=6; in_len=0 → done at t+N_CH+4 with out_cnt=0.

Source files
------------

// File: rtl/blk_ctrl_pkg.sv
// Shared Block-stage control definitions.
// State encoding and default pooling geometry.
package blk_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned KERNEL_DEF = 7;
  localparam int unsigned STRIDE_DEF = 2;

endpackage

// File: rtl/maxpool_thre_ctrl_if.sv
// Conv sample stream into the max-pool controller.
// Upstream presents in_val; controller answers in_rdy.
interface maxpool_thre_ctrl_if;

  logic in_val;
  logic in_rdy;

  modport master (
    output in_val,
    input  in_rdy
  );

  modport slave (
    input  in_val,
    output in_rdy
  );

endinterface

// File: rtl/thre_loader.sv
// Threshold loader: walks ROM addresses, then strobes
// one channel per cycle once the read data has arrived.
module thre_loader #(
  parameter int unsigned N_CH   = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go_i,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [N_CH-1:0]   load_strobe_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_CH - 1);

  logic              en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [N_CH-1:0]   strobe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      addr_q   <= '0;
      strobe_q <= '0;
    end else begin
      // strobe lags the address by the ROM read latency
      strobe_q <= '0;
      if (en_q)
        strobe_q <= {{(N_CH-1){1'b0}}, 1'b1} << addr_q;
      if (go_i && !en_q) begin
        en_q   <= 1'b1;
        addr_q <= '0;
      end else if (en_q) begin
        if (addr_q == LAST) begin
          en_q   <= 1'b0;
          addr_q <= '0;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  assign rom_en_o      = en_q;
  assign rom_addr_o    = addr_q;
  assign load_strobe_o = strobe_q;
  assign last_o        = strobe_q[N_CH-1];

endmodule

// File: rtl/maxpool_thre_ctrl.sv
// Frame controller for one Block's max-pool/threshold
// stage: threshold load, window sequencing, end-of-frame.
module maxpool_thre_ctrl
  import blk_ctrl_pkg::*;
#(
  parameter int unsigned N_CH   = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned KERNEL = KERNEL_DEF,
  parameter int unsigned STRIDE = STRIDE_DEF,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  in_len_i,
  maxpool_thre_ctrl_if.slave in_if,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [N_CH-1:0]   load_strobe_o,
  output logic              win_fire_o,
  output logic              out_val_o,
  output logic [LEN_W-1:0]  out_cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned PH_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [LEN_W-1:0] K_LAST = LEN_W'(KERNEL - 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(STRIDE - 1);

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] k_q;
  logic [PH_W-1:0]  ph_q;
  logic [LEN_W-1:0] cnt_q;
  logic             in_rdy_q;
  logic             out_val_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic go;
  logic ld_last;
  logic accept;
  logic fire;

  assign go     = (state_q == IDLE) && start_i;
  assign accept = in_rdy_q && in_if.in_val && (len_q != '0);
  // ph_q tracks the stride phase once the first window is full
  assign fire   = accept && (k_q >= K_LAST) && (ph_q == '0);

  thre_loader #(
    .N_CH  (N_CH),
    .ADDR_W(ADDR_W)
  ) u_loader (
    .clk          (clk),
    .rst          (rst),
    .go_i         (go),
    .rom_en_o     (rom_en_o),
    .rom_addr_o   (rom_addr_o),
    .load_strobe_o(load_strobe_o),
    .last_o       (ld_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      k_q       <= '0;
      ph_q      <= '0;
      cnt_q     <= '0;
      in_rdy_q  <= 1'b0;
      out_val_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      out_val_q <= fire;
      done_q    <= 1'b0;
      if (fire && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
      if (in_if.in_val && !in_rdy_q)
        err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            len_q   <= in_len_i;
            k_q     <= '0;
            ph_q    <= '0;
            cnt_q   <= '0;
            err_q   <= in_if.in_val;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (ld_last) begin
            in_rdy_q <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (len_q == '0) begin
            in_rdy_q <= 1'b0;
            state_q  <= DRAIN;
          end else if (accept) begin
            k_q <= k_q + 1'b1;
            if (k_q >= K_LAST)
              ph_q <= (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
            if (k_q == len_q - 1'b1) begin
              in_rdy_q <= 1'b0;
              state_q  <= DRAIN;
            end
          end
        end
        DRAIN: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_if.in_rdy = in_rdy_q;
  assign win_fire_o   = fire;
  assign out_val_o    = out_val_q;
  assign out_cnt_o    = cnt_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
